gtxe2_chnl_outdiv: RTL and testbench



---
 rtl/gtxe2_chnl_outdiv_pkg.sv | 40 ++++
 rtl/gtxe2_chnl_outdiv_cnt.sv | 43 ++++
 rtl/gtxe2_chnl_outdiv.sv | 127 ++++++++++++
 tb/tb_gtxe2_chnl_outdiv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gtxe2_chnl_outdiv_pkg.sv
// gtxe2_chnl_outdiv_pkg: shared RATE encodings, FSM states and divider helpers
// for the CPLL output divider stage.
`default_nettype none

package gtxe2_chnl_outdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [2:0] RATE_DFLT  = 3'd0;
    localparam logic [2:0] RATE_DIV1  = 3'd1;
    localparam logic [2:0] RATE_DIV2  = 3'd2;
    localparam logic [2:0] RATE_DIV4  = 3'd3;
    localparam logic [2:0] RATE_DIV8  = 3'd4;
    localparam logic [2:0] RATE_DIV16 = 3'd5;

    function automatic logic is_legal_div(input int d);
        return (d == 1) || (d == 2) || (d == 4) || (d == 8) || (d == 16);
    endfunction

    // Codes 6 and 7 are reserved and fall back to the default divider.
    function automatic logic [4:0] decode_rate(input logic [2:0] rate,
                                               input logic [4:0] dflt);
        case (rate)
            RATE_DIV1:  return 5'd1;
            RATE_DIV2:  return 5'd2;
            RATE_DIV4:  return 5'd4;
            RATE_DIV8:  return 5'd8;
            RATE_DIV16: return 5'd16;
            default:    return dflt;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/gtxe2_chnl_outdiv_cnt.sv
// gtxe2_chnl_outdiv_cnt: programmable toggle counter, counts 0..div-1 and
// strobes on the last count (toggle) and on the last count while high (fall).
`default_nettype none

module gtxe2_chnl_outdiv_cnt (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [4:0] div_i,
    input  logic       lvl_i,
    output logic       tgl_o,
    output logic       fall_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       w_last;

    assign w_last = ({1'b0, cnt_q} == (div_i - 5'd1));
    assign tgl_o  = en_i & w_last;
    assign fall_o = tgl_o & lvl_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (en_i) begin
            cnt_d = w_last ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gtxe2_chnl_outdiv.sv
// gtxe2_chnl_outdiv: divides the CPLL clock by a RATE-selected divider and
// sequences glitch-free rate changes through DRAIN/HOLD with a RATEDONE pulse.
`default_nettype none

module gtxe2_chnl_outdiv
    import gtxe2_chnl_outdiv_pkg::*;
#(
    parameter int OUT_DIV     = 2,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       pll_clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic [2:0] RATE,
    output logic       div_clk,
    output logic       div_ready,
    output logic       RATEDONE
);

    localparam logic [4:0] c_out_div   = 5'(OUT_DIV);
    localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);

    if (!is_legal_div(OUT_DIV)) begin : g_bad_out_div
        $fatal(1, "gtxe2_chnl_outdiv: OUT_DIV must be 1, 2, 4, 8 or 16");
    end
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
        $fatal(1, "gtxe2_chnl_outdiv: HOLD_CYCLES must be 1..255");
    end

    state_t     state_q;
    logic       div_clk_q;
    logic       ready_q;
    logic       ratedone_q;
    logic [4:0] cur_d_q;
    logic [7:0] hold_q;

    logic [4:0] w_rate_dec;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_tgl;
    logic       w_fall;

    assign w_rate_dec = decode_rate(RATE, c_out_div);
    assign w_cnt_clr  = !pll_locked || (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign w_cnt_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    gtxe2_chnl_outdiv_cnt u_cnt (
        .clk_i   (pll_clk),
        .rst_n_i (rst_n),
        .clr_i   (w_cnt_clr),
        .en_i    (w_cnt_en),
        .div_i   (cur_d_q),
        .lvl_i   (div_clk_q),
        .tgl_o   (w_tgl),
        .fall_o  (w_fall)
    );

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_clk_q  <= 1'b0;
            ready_q    <= 1'b0;
            ratedone_q <= 1'b0;
            cur_d_q    <= c_out_div;
            hold_q     <= 8'd0;
        end else begin
            ratedone_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                cur_d_q <= w_rate_dec;
            end
            if (!pll_locked) begin
                state_q   <= ST_IDLE;
                div_clk_q <= 1'b0;
                ready_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        div_clk_q <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (w_tgl) begin
                            div_clk_q <= ~div_clk_q;
                        end
                        if (w_rate_dec != cur_d_q) begin
                            state_q <= ST_DRAIN;
                            ready_q <= 1'b0;
                        end else if (w_tgl && !div_clk_q) begin
                            ready_q <= 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        // Leave only on a falling toggle so the last high phase is whole.
                        if (w_fall) begin
                            div_clk_q <= 1'b0;
                            hold_q    <= 8'd0;
                            state_q   <= ST_HOLD;
                        end else if (w_tgl) begin
                            div_clk_q <= ~div_clk_q;
                        end
                    end
                    ST_HOLD: begin
                        div_clk_q <= 1'b0;
                        if (hold_q == c_hold_last) begin
                            cur_d_q    <= w_rate_dec;
                            state_q    <= ST_RUN;
                            ratedone_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 8'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign div_clk   = div_clk_q;
    assign div_ready = ready_q;
    assign RATEDONE  = ratedone_q;

endmodule

`default_nettype wire

// File: tb/tb_gtxe2_chnl_outdiv.sv
// tb_gtxe2_chnl_outdiv: directed scenarios plus randomized RATE/lock/reset
// traffic, checked cycle by cycle against a phase-arithmetic reference model.
`default_nettype none

module tb_gtxe2_chnl_outdiv;

    localparam int OUT_DIV = 2;
    localparam int HOLD    = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HOLD  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic [2:0] rate;
    logic       div_clk;
    logic       div_ready;
    logic       ratedone;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: t counts edges since entering RUN, so the
    // divided clock level is simply (t / D) mod 2.
    int m_mode;
    int m_t;
    int m_h;
    int m_d;
    bit e_clk;
    bit e_rdy;
    bit e_done;

    always #5 clk = ~clk;

    gtxe2_chnl_outdiv #(
        .OUT_DIV     (OUT_DIV),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .pll_clk    (clk),
        .rst_n      (rst_n),
        .pll_locked (locked),
        .RATE       (rate),
        .div_clk    (div_clk),
        .div_ready  (div_ready),
        .RATEDONE   (ratedone)
    );

    function automatic int dec(input logic [2:0] r);
        int tbl[8];
        tbl = '{OUT_DIV, 1, 2, 4, 8, 16, OUT_DIV, OUT_DIV};
        return tbl[r];
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_h = 0; m_d = OUT_DIV;
        e_clk = 0; e_rdy = 0; e_done = 0;
    endtask

    task automatic model_edge();
        e_done = 0;
        if (m_mode == M_IDLE) m_d = dec(rate);
        if (!locked) begin
            m_mode = M_IDLE; e_clk = 0; e_rdy = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_RUN; m_t = 0; e_clk = 0; e_rdy = 0;
                end
                M_RUN: begin
                    m_t++;
                    e_clk = ((m_t / m_d) % 2) == 1;
                    if (dec(rate) != m_d) begin
                        m_mode = M_DRAIN; e_rdy = 0;
                    end else if ((m_t % (2 * m_d)) == m_d) begin
                        e_rdy = 1;
                    end
                end
                M_DRAIN: begin
                    m_t++;
                    if ((m_t % (2 * m_d)) == 0) begin
                        e_clk = 0; m_mode = M_HOLD; m_h = 0;
                    end else begin
                        e_clk = ((m_t / m_d) % 2) == 1;
                    end
                end
                default: begin
                    m_h++; e_clk = 0;
                    if (m_h == HOLD) begin
                        m_d = dec(rate); m_mode = M_RUN; m_t = 0; e_done = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic check_outs();
        check_eq("div_clk",   int'(div_clk),   int'(e_clk));
        check_eq("div_ready", int'(div_ready), int'(e_rdy));
        check_eq("RATEDONE",  int'(ratedone),  int'(e_done));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_outs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_div_clk",   int'(div_clk),   0);
        check_eq("async_div_ready", int'(div_ready), 0);
        check_eq("async_RATEDONE",  int'(ratedone),  0);
        run(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_mode(input int mode, input int h, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (m_mode == mode && (mode != M_HOLD || m_h == h)) break;
            step();
        end
        if (i == budget) check_eq("wait_timeout", 0, 1);
    endtask

    initial begin
        int pulses;
        int cyc;
        rst_n  = 1'b0;
        locked = 1'b0;
        rate   = 3'd0;
        model_reset();

        // Reset, then lock at cycle 10 with the default divider.
        run(5);
        check_eq("reset_div_clk",   int'(div_clk),   0);
        check_eq("reset_div_ready", int'(div_ready), 0);
        check_eq("reset_RATEDONE",  int'(ratedone),  0);
        rst_n = 1'b1;
        run(4);
        locked = 1'b1;
        run(1);
        run(1);
        check_eq("lock_no_rise_yet", int'(div_clk), 0);
        run(1);
        check_eq("first_rise", int'(div_clk), 1);
        check_eq("first_ready", int'(div_ready), 1);
        run(30);

        // Rate change to /8 in the middle of a high phase.
        cyc = 0;
        while (!(div_clk === 1'b1) && cyc < 20) begin step(); cyc++; end
        rate = 3'd4;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin step(); pulses += int'(ratedone); end
        check_eq("div8_done_pulses", pulses, 1);

        // Several writes during one drain/hold window, ending at /1.
        rate = 3'd3;
        run(3);
        rate = 3'd5;
        run(3);
        rate = 3'd1;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin step(); pulses += int'(ratedone); end
        check_eq("multi_write_pulses", pulses, 1);

        // Back to the default divider, then a change that ends on the same divider.
        rate = 3'd0;
        run(40);
        rate = 3'd3;
        run(1);
        rate = 3'd2;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin step(); pulses += int'(ratedone); end
        check_eq("same_div_pulses", pulses, 1);

        // Lock loss in the middle of HOLD aborts the change.
        rate = 3'd4;
        wait_mode(M_HOLD, 3, 100);
        locked = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin step(); pulses += int'(ratedone); end
        check_eq("lockloss_pulses", pulses, 0);
        locked = 1'b1;
        run(40);

        // Asynchronous reset mid-run, then a reserved RATE code.
        async_reset();
        rate = 3'd7;
        run(30);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) rate = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) locked = ~locked;
            else if (!locked && $urandom_range(0, 9) == 0) locked = 1'b1;
            if ($urandom_range(0, 799) == 0) async_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
